// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
//   Read-only, direct-mapped instruction cache: 8 sets of 16-byte (4-word)
//   blocks. Hits are served combinationally; a miss stalls the fetch stage
//   while the block is fetched from instruction memory and written into the
//   indexed entry.
//
// Ports
//   clock         in   1    system clock, rising-edge active
//   reset         in   1    asynchronous, active-high reset
//   address       in   32   fetch address: [31:7] tag, [6:4] index,
//                           [3:2] word offset, [1:0] unused
//   readdata      out  32   instruction word, valid while busywait=0
//   busywait      out  1    stall request to the fetch stage
//   mem_read      out  1    block read request to instruction memory
//   mem_address   out  28   block address {tag,index} of the missing block
//   mem_readdata  in   128  returned block, word0 in [31:0]
//   mem_busywait  in   1    memory stall; read completes when low
// -----------------------------------------------------------------------------
module instruction_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  address,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t         state_r;
  state_t         next_state_s;

  logic [7:0]     valid_r;
  logic [24:0]    tag_r  [8];
  logic [127:0]   data_r [8];
  logic [127:0]   fill_r;
  logic [27:0]    miss_r;

  logic [2:0]     index_s;
  logic [24:0]    tag_s;
  logic [1:0]     offset_s;
  logic           hit_s;
  logic           unused_bits_s;

  // Selects one 32-bit word of a 128-bit block by word offset.
  function automatic logic [31:0] select_word(input logic [127:0] block,
                                              input logic [1:0]   offset);
    logic [31:0] word;
    case (offset)
      2'd0:    word = block[31:0];
      2'd1:    word = block[63:32];
      2'd2:    word = block[95:64];
      2'd3:    word = block[127:96];
      default: word = block[31:0];
    endcase
    return word;
  endfunction

  assign index_s       = address[6:4];
  assign tag_s         = address[31:7];
  assign offset_s      = address[3:2];
  // Byte-offset bits are not used by a word-fetch cache.
  assign unused_bits_s = ^address[1:0];

  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign readdata    = select_word(data_r[index_s], offset_s);
  // Driven from the miss register so a wandering fetch address cannot
  // disturb an outstanding block request.
  assign mem_address = miss_r;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!hit_s) begin
          next_state_s = MEM_READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          next_state_s = UPDATE;
        end else begin
          next_state_s = MEM_READ;
        end
      end
      UPDATE:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; reset overrides so the stall and the request drop at once.
  always_comb begin
    mem_read = 1'b0;
    busywait = 1'b0;
    if (reset) begin
      mem_read = 1'b0;
      busywait = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_read = 1'b0;
          busywait = !hit_s;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          busywait = 1'b1;
        end
        UPDATE: begin
          mem_read = 1'b0;
          busywait = 1'b1;
        end
        default: begin
          mem_read = 1'b0;
          busywait = 1'b0;
        end
      endcase
    end
  end

  // Miss register and valid bits; both are cleared by reset, which also
  // cancels any fill in flight since UPDATE can no longer be reached.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_r  <= 28'd0;
      valid_r <= 8'd0;
    end else begin
      if ((state_r == IDLE) && !hit_s) begin
        miss_r <= {tag_s, index_s};
      end
      if (state_r == UPDATE) begin
        valid_r[miss_r[2:0]] <= 1'b1;
      end
    end
  end

  // Fill buffer and tag/data arrays; contents are qualified by valid_r so
  // they carry no reset.
  always_ff @(posedge clock) begin
    if ((state_r == MEM_READ) && !mem_busywait) begin
      fill_r <= mem_readdata;
    end
    if (state_r == UPDATE) begin
      tag_r[miss_r[2:0]]  <= miss_r[27:3];
      data_r[miss_r[2:0]] <= fill_r;
    end
  end

endmodule
